// File: rtl/ps2_key_encoder.sv
// Packs PS/2 scancode bytes into the 65-bit ps2_key event vector (toggle + up to 8 bytes).
// Optional idle timeout on partial sequences: define PS2_KEY_TIMEOUT_EN.
module ps2_key_encoder #(
   parameter int TIMEOUT = 2000000,
   parameter int TW      = 21
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic        byte_err,
   output logic [64:0] ps2_key,
   output logic        key_strobe,
   output logic        seq_drop
);

   typedef enum logic [1:0] {IDLE, COLLECT, PAUSE} state_t;

   state_t      state_q, state_d;
   // Only seven bytes are ever held; the eighth goes straight into ps2_key on commit.
   logic [55:0] sr_q, sr_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [64:0] key_q, key_d;
   logic        strobe_q, strobe_d;
   logic        drop_q, drop_d;

   logic        ignored, take, cont, accepted, do_commit, do_drop, do_append;
   logic [63:0] s_nxt;
   logic [3:0]  cnt_nxt;

   always_comb begin
      ignored = byte_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};
      take    = byte_valid && !byte_err && (state_q == PAUSE || !ignored);
      s_nxt   = {sr_q, byte_data};
      cnt_nxt = cnt_q + 4'd1;
      cont    = (byte_data == 8'hE0) || (byte_data == 8'hF0) ||
                (cnt_nxt == 4'd2 && s_nxt[15:0] == 16'hE012) ||
                (cnt_nxt == 4'd3 && s_nxt[23:0] == 24'hE0F07C);
   end

`ifdef PS2_KEY_TIMEOUT_EN
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tmo_hit;
   assign tmo_hit = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT - 1));
`else
   logic unused_cfg;
   logic tmo_hit;
   assign unused_cfg = ^(TW'(TIMEOUT));
   assign tmo_hit    = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      key_d     = key_q;
      strobe_d  = 1'b0;
      drop_d    = 1'b0;
      accepted  = 1'b0;
      do_commit = 1'b0;
      do_drop   = 1'b0;
      do_append = 1'b0;

      if (byte_err && state_q != IDLE) begin
         do_drop = 1'b1;
      end else if (take) begin
         accepted = 1'b1;
         case (state_q)
            IDLE: begin
               if (byte_data == 8'hE1) begin
                  do_append = 1'b1;
                  state_d   = PAUSE;
               end else if (cont) begin
                  do_append = 1'b1;
                  state_d   = COLLECT;
               end else begin
                  do_commit = 1'b1;
               end
            end
            COLLECT: begin
               if (cnt_q == 4'd8)  do_drop   = 1'b1;
               else if (cont)      do_append = 1'b1;
               else                do_commit = 1'b1;
            end
            PAUSE: begin
               if (cnt_nxt == 4'd8) do_commit = 1'b1;
               else                 do_append = 1'b1;
            end
            default: do_drop = 1'b1;
         endcase
      end else if (tmo_hit) begin
         do_drop = 1'b1;
      end

      if (do_append) begin
         sr_d  = s_nxt[55:0];
         cnt_d = cnt_nxt;
      end
      if (do_commit) begin
         key_d    = {~key_q[64], s_nxt};
         strobe_d = 1'b1;
      end
      if (do_drop) drop_d = 1'b1;
      if (do_commit || do_drop) begin
         sr_d    = '0;
         cnt_d   = '0;
         state_d = IDLE;
      end
   end

`ifdef PS2_KEY_TIMEOUT_EN
   always_comb begin
      tmo_d = tmo_q + 1'b1;
      if (accepted || state_d == IDLE) tmo_d = '0;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q  <= IDLE;
         sr_q     <= '0;
         cnt_q    <= '0;
         key_q    <= '0;
         strobe_q <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         key_q    <= key_d;
         strobe_q <= strobe_d;
         drop_q   <= drop_d;
      end
   end

   assign ps2_key    = key_q;
   assign key_strobe = strobe_q;
   assign seq_drop   = drop_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed + random bench for ps2_key_encoder against a queue-based sequence model.
module tb_ps2_key_encoder;

   localparam int TMO = 100;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_err = 1'b0;
   logic [64:0] ps2_key;
   logic        key_strobe;
   logic        seq_drop;

   int checks = 0;
   int errors = 0;

   ps2_key_encoder #(.TIMEOUT(TMO), .TW(8)) dut (
      .clk_sys(clk_sys), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_err(byte_err), .ps2_key(ps2_key), .key_strobe(key_strobe), .seq_drop(seq_drop)
   );

   always #5 clk_sys = ~clk_sys;

   // Reference model: pending bytes kept as a queue; PAUSE mode is "sequence starts with E1".
   logic [7:0]  q[$];
   logic [64:0] exp_key = '0;
   logic        exp_stb = 1'b0;
   logic        exp_drop = 1'b0;
   int          m_idle = 0;

   function automatic bit is_ignored(input logic [7:0] b);
      return b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE ||
             b == 8'hFC || b == 8'h00 || b == 8'hFF;
   endfunction

   function automatic void m_commit();
      logic [63:0] v;
      v = '0;
      foreach (q[i]) v = (v << 8) | 64'(q[i]);
      exp_key = {~exp_key[64], v};
      exp_stb = 1'b1;
      q.delete();
   endfunction

   function automatic void m_drop();
      exp_drop = 1'b1;
      q.delete();
   endfunction

   function automatic void m_step(input bit v, input logic [7:0] b, input bit e, input bit r);
      bit in_pause, acc, more;
      exp_stb = 1'b0;
      exp_drop = 1'b0;
      acc = 1'b0;
      if (r) begin
         q.delete();
         exp_key = '0;
         m_idle = 0;
         return;
      end
      in_pause = q.size() > 0 && q[0] == 8'hE1;
      if (e) begin
         if (q.size() > 0) m_drop();
         m_idle = 0;
         return;
      end
      if (v) begin
         if (in_pause) begin
            acc = 1'b1;
            q.push_back(b);
            if (q.size() == 8) m_commit();
         end else if (!is_ignored(b)) begin
            acc = 1'b1;
            if (q.size() == 8) m_drop();
            else begin
               q.push_back(b);
               more = (b == 8'hE0) || (b == 8'hF0) ||
                      (q.size() == 1 && b == 8'hE1) ||
                      (q.size() == 2 && q[0] == 8'hE0 && q[1] == 8'h12) ||
                      (q.size() == 3 && q[0] == 8'hE0 && q[1] == 8'hF0 && q[2] == 8'h7C);
               if (!more) m_commit();
            end
         end
      end
      if (acc || q.size() == 0) m_idle = 0;
`ifdef PS2_KEY_TIMEOUT_EN
      else begin
         m_idle++;
         if (m_idle == TMO) begin
            m_drop();
            m_idle = 0;
         end
      end
`endif
   endfunction

   task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input bit v, input logic [7:0] b, input bit e, input bit r);
      byte_valid = v;
      byte_data  = b;
      byte_err   = e;
      reset      = r;
      m_step(v, b, e, r);
      @(posedge clk_sys);
      @(negedge clk_sys);
      byte_valid = 1'b0;
      byte_err   = 1'b0;
      reset      = 1'b0;
      chk("ps2_key", ps2_key, exp_key);
      chk("key_strobe", 65'(key_strobe), 65'(exp_stb));
      chk("seq_drop", 65'(seq_drop), 65'(exp_drop));
   endtask

   task automatic send(input logic [7:0] b);
      cyc(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   logic [7:0] pool[14] = '{8'hE0, 8'hF0, 8'h12, 8'h7C, 8'h1C, 8'h75, 8'hE1,
                            8'hFA, 8'hAA, 8'h00, 8'hFF, 8'h29, 8'h14, 8'h77};

   initial begin
      @(negedge clk_sys);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("reset_key", ps2_key, 65'd0);
      idle(2);

      send(8'h1C);
      chk("make_1C", ps2_key, {1'b1, 64'h1C});
      idle(1);
      send(8'hF0); send(8'h1C);
      chk("break_1C", ps2_key, {1'b0, 64'hF01C});

      send(8'hE0); send(8'hF0); send(8'h75);
      chk("ext_break", ps2_key, {1'b1, 64'hE0F075});

      send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
      chk("prnscr_make", ps2_key, {1'b0, 64'hE012E07C});
      send(8'hE0); send(8'hF0); send(8'h7C); send(8'hE0); send(8'hF0); send(8'h12);
      chk("prnscr_break", ps2_key, {1'b1, 64'hE0F07CE0F012});

      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      chk("pause", ps2_key, {1'b0, 64'hE11477E1F014F077});

      send(8'hE0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("err_drop", 65'(seq_drop), 65'd1);
      send(8'h1C);
      chk("after_err", ps2_key, {1'b1, 64'h1C});
      cyc(1'b1, 8'h29, 1'b1, 1'b0);   // error in IDLE with a byte: byte lost, nothing else

      for (int i = 0; i < 8; i++) send(8'hF0);
      send(8'hF0);
      chk("overflow_drop", 65'(seq_drop), 65'd1);
      send(8'hFA);
      send(8'h1C);

      send(8'hF0);
      idle(TMO + 2);
      send(8'hFA);
      idle(1);
      send(8'h1C);

      send(8'hE0); send(8'hF0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("midreset_key", ps2_key, 65'd0);
      send(8'h29);
      chk("post_reset", ps2_key, {1'b1, 64'h29});

      for (int i = 0; i < 1500; i++) begin
         int r;
         r = int'($urandom_range(0, 199));
         if (r < 110)      send(pool[$urandom_range(0, 13)]);
         else if (r < 114) cyc(1'b0, 8'h00, 1'b1, 1'b0);
         else if (r < 117) cyc(1'b1, pool[$urandom_range(0, 13)], 1'b1, 1'b0);
         else if (r == 199) cyc(1'b0, 8'h00, 1'b0, 1'b1);
         else if (r == 198) idle(TMO + 1);
         else              idle(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
